// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: default geometry,
// instruction type codes carried in the top two bits of every word, and the
// fetch controller state encoding.
package instr_fetch_pkg;

   localparam int INSTR_WIDTH = 20;
   localparam int ADDR_BITS   = 5;

   // Instruction class, taken from the two most significant bits of a word.
   typedef enum logic [1:0] {
      ITYPE_HALT    = 2'b00,   // halt / nop
      ITYPE_STD_OP  = 2'b01,
      ITYPE_LOAD_R  = 2'b10,
      ITYPE_STORE_R = 2'b11
   } instr_type_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FETCH = 2'b01,
      ST_HOLD  = 2'b10,
      ST_HALT  = 2'b11
   } fetch_state_e;

   // Classify a word from its two type bits.
   function automatic instr_type_e instr_type(input logic [1:0] type_bits);
      return instr_type_e'(type_bits);
   endfunction

endpackage

// File: rtl/instr_mem.sv
// Program store: 2^ADDR_BITS words, one write port and one synchronous read
// port. Read data appears the cycle after re_i is sampled and holds until the
// next read.
module instr_mem #(
   parameter int INSTR_WIDTH = 20,
   parameter int ADDR_BITS   = 5
) (
   input  logic                   clk,
   input  logic                   we_i,
   input  logic [ADDR_BITS-1:0]   waddr_i,
   input  logic [INSTR_WIDTH-1:0] wdata_i,
   input  logic                   re_i,
   input  logic [ADDR_BITS-1:0]   raddr_i,
   output logic [INSTR_WIDTH-1:0] rdata_o
);

   logic [INSTR_WIDTH-1:0] mem_q [0:(1<<ADDR_BITS)-1];
   logic [INSTR_WIDTH-1:0] rdata_q;

   // Write port and registered read port.
   // NOTE: sequential state uses <= so every register samples pre-edge values;
   // blocking = here would make read-after-write order depend on statement order.
   // NOTE: the storage array has no reset: a loaded program must survive rst,
   // and a resettable array could not map onto a RAM macro.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks the program store from address 0, presents one
// word at a time to the control unit, and waits for advance before fetching
// the next (sequential or jump target). A word of type 00 stops the walk.
module instr_fetch #(
   parameter int INSTR_WIDTH = instr_fetch_pkg::INSTR_WIDTH,
   parameter int ADDR_BITS   = instr_fetch_pkg::ADDR_BITS
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   ld_en,
   input  logic [ADDR_BITS-1:0]   ld_addr,
   input  logic [INSTR_WIDTH-1:0] ld_data,
   input  logic                   advance,
   input  logic                   jump_en,
   input  logic [ADDR_BITS-1:0]   jump_addr,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic                   instr_valid,
   output logic [ADDR_BITS-1:0]   pc,
   output logic                   halted
);

   import instr_fetch_pkg::*;

   fetch_state_e           state_q, state_d;
   logic [ADDR_BITS-1:0]   pc_q, pc_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic                   valid_q, valid_d;
   logic                   halted_q, halted_d;
   // Memory read data for pc_q is available this cycle.
   logic                   rd_ready_q, rd_ready_d;

   logic                   mem_we;
   logic                   mem_re;
   logic [ADDR_BITS-1:0]   mem_raddr;
   logic [INSTR_WIDTH-1:0] mem_rdata;

   instr_mem #(
      .INSTR_WIDTH (INSTR_WIDTH),
      .ADDR_BITS   (ADDR_BITS)
   ) u_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (ld_addr),
      .wdata_i (ld_data),
      .re_i    (mem_re),
      .raddr_i (mem_raddr),
      .rdata_o (mem_rdata)
   );

   // Next-state, next-PC and memory port control.
   // Loads are only accepted while stopped, and reads are only issued while
   // running, so a write and a read never target the memory in the same cycle.
   // A cold start therefore reads from FETCH (one extra cycle), whereas an
   // advance issues the read for the next address on the same edge that
   // enters FETCH, giving one new word every other cycle under steady advance.
   always_comb begin
      // NOTE: every output of this block gets a default first; a path that
      // left one unassigned would infer a latch.
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      valid_d    = valid_q;
      halted_d   = halted_q;
      rd_ready_d = rd_ready_q;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      mem_raddr  = pc_q;

      unique case (state_q)
         ST_IDLE: begin
            mem_we = ld_en;
            if (start) begin
               state_d    = ST_FETCH;
               pc_d       = '0;
               rd_ready_d = 1'b0;
            end
         end

         ST_FETCH: begin
            if (rd_ready_q) begin
               instr_d    = mem_rdata;
               rd_ready_d = 1'b0;
               if (instr_type(mem_rdata[INSTR_WIDTH-1 -: 2]) == ITYPE_HALT) begin
                  state_d  = ST_HALT;
                  valid_d  = 1'b0;
                  halted_d = 1'b1;
               end else begin
                  state_d  = ST_HOLD;
                  valid_d  = 1'b1;
               end
            end else begin
               mem_re     = 1'b1;
               rd_ready_d = 1'b1;
            end
         end

         ST_HOLD: begin
            if (advance) begin
               pc_d       = jump_en ? jump_addr : pc_q + 1'b1;
               mem_re     = 1'b1;
               mem_raddr  = pc_d;
               rd_ready_d = 1'b1;
               valid_d    = 1'b0;
               state_d    = ST_FETCH;
            end
         end

         ST_HALT: begin
            mem_we = ld_en;
            if (start) begin
               state_d    = ST_FETCH;
               pc_d       = '0;
               halted_d   = 1'b0;
               rd_ready_d = 1'b0;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset; memory is untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pc_q       <= '0;
         instr_q    <= '0;
         valid_q    <= 1'b0;
         halted_q   <= 1'b0;
         rd_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         valid_q    <= valid_d;
         halted_q   <= halted_d;
         rd_ready_q <= rd_ready_d;
      end
   end

   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign pc          = pc_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch. The driver keeps a program image and the
// address it expects to be presented next; every start/advance pushes the
// expected word, address, kind (halt or not) and arrival cycle. The monitor
// pops on each new instr_valid or halted and checks held values in between.
module tb_instr_fetch;

   localparam int IW    = 20;
   localparam int AB    = 5;
   localparam int DEPTH = 1 << AB;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          ld_en;
   logic [AB-1:0] ld_addr;
   logic [IW-1:0] ld_data;
   logic          advance;
   logic          jump_en;
   logic [AB-1:0] jump_addr;
   logic [IW-1:0] instr;
   logic          instr_valid;
   logic [AB-1:0] pc;
   logic          halted;

   always #5 clk = ~clk;

   instr_fetch #(.INSTR_WIDTH(IW), .ADDR_BITS(AB)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .ld_en       (ld_en),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .advance     (advance),
      .jump_en     (jump_en),
      .jump_addr   (jump_addr),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc          (pc),
      .halted      (halted)
   );

   typedef struct {
      bit            is_halt;
      logic [AB-1:0] addr;
      logic [IW-1:0] word;
      int            due;
   } exp_t;

   typedef enum {M_IDLE, M_RUN, M_STOPPED} mode_e;

   exp_t          exp_q[$];
   int            vectors     = 0;
   int            miscompares = 0;
   int            cyc         = 0;
   logic [IW-1:0] model_mem [DEPTH];
   mode_e         m_mode      = M_IDLE;
   int            m_pc        = 0;

   // Monitor bookkeeping.
   bit            prev_valid  = 1'b0;
   bit            prev_halted = 1'b0;
   logic [IW-1:0] last_instr  = '0;
   logic [AB-1:0] last_pc     = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Record what the DUT must present once it has fetched model_mem[a].
   task automatic expect_word(input int a, input int due);
      exp_t e;
      e.addr    = AB'(a);
      e.word    = model_mem[a];
      e.is_halt = (model_mem[a] >> (IW - 2)) == 0;
      e.due     = due;
      exp_q.push_back(e);
      m_pc   = a;
      m_mode = e.is_halt ? M_STOPPED : M_RUN;
   endtask

   task automatic load_word(input int a, input logic [IW-1:0] d);
      ld_en   = 1'b1;
      ld_addr = AB'(a);
      ld_data = d;
      if (m_mode != M_RUN) model_mem[a] = d;
      tick();
      ld_en = 1'b0;
   endtask

   // Start is sampled on the next edge; the word shows up two edges later.
   task automatic do_start();
      start = 1'b1;
      if (m_mode != M_RUN) expect_word(0, cyc + 3);
      tick();
      start = 1'b0;
   endtask

   // Advance is sampled on the next edge; the next word shows up one edge later.
   task automatic do_advance(input bit jmp, input int ja);
      int nxt;
      advance   = 1'b1;
      jump_en   = jmp;
      jump_addr = AB'(ja);
      nxt = jmp ? ja : (m_pc + 1) % DEPTH;
      if (m_mode == M_RUN) expect_word(nxt, cyc + 2);
      tick();
      advance = 1'b0;
      jump_en = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL timeout: %0d expected outputs still outstanding after %0d cycles", exp_q.size(), budget);
         exp_q.delete();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      check("rst_instr", 32'(instr), 32'd0);
      check("rst_pc", 32'(pc), 32'd0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      rst = 1'b0;
      exp_q.delete();
      m_mode = M_IDLE;
      m_pc   = 0;
   endtask

   function automatic logic [IW-1:0] rand_word(input bit allow_halt);
      logic [IW-1:0] w;
      w = IW'($urandom);
      if (allow_halt && $urandom_range(7) == 0) w[IW-1 -: 2] = 2'b00;
      else if (w[IW-1 -: 2] == 2'b00) w[IW-1 -: 2] = 2'($urandom_range(3, 1));
      return w;
   endfunction

   // Monitor: pop on every new output event, check held values in between.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (instr_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_valid: pc %0d instr 'h%0h with nothing expected", pc, instr);
            end else begin
               e = exp_q.pop_front();
               check("valid_vs_halt_word", 32'(halted), 32'(e.is_halt));
               check("instr", 32'(instr), 32'(e.word));
               check("pc", 32'(pc), 32'(e.addr));
               check("valid_latency", 32'(cyc), 32'(e.due));
            end
            last_instr = instr;
            last_pc    = pc;
         end else if (instr_valid && prev_valid) begin
            check("hold_instr", 32'(instr), 32'(last_instr));
            check("hold_pc", 32'(pc), 32'(last_pc));
         end
         if (halted && !prev_halted) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_halt: pc %0d with nothing expected", pc);
            end else begin
               e = exp_q.pop_front();
               check("halt_vs_word", 32'(instr_valid), 32'(!e.is_halt));
               check("halt_pc", 32'(pc), 32'(e.addr));
               check("halt_latency", 32'(cyc), 32'(e.due));
            end
         end
         prev_valid  = instr_valid;
         prev_halted = halted;
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [IW-1:0] old_word;
      rst = 1'b1; start = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      advance = 1'b0; jump_en = 1'b0; jump_addr = '0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      tick();
      tick();
      do_reset();

      // Single std_op then halt.
      load_word(0, 20'h4_1235);
      load_word(1, 20'h0_0000);
      do_start();
      drain(20);
      do_advance(1'b0, 0);
      drain(20);
      check("t1_halted", 32'(halted), 32'd1);
      check("t1_valid", 32'(instr_valid), 32'd0);
      check("t1_pc", 32'(pc), 32'd1);

      // Continuous advance over three std_ops and a halt.
      for (int i = 0; i < 3; i++) load_word(i, 20'h4_0000 | IW'(i + 1));
      load_word(3, 20'h0_0abc);
      begin
         int k;
         k = cyc;
         start   = 1'b1;
         advance = 1'b1;
         expect_word(0, k + 3);
         expect_word(1, k + 5);
         expect_word(2, k + 7);
         expect_word(3, k + 9);
         tick();
         start = 1'b0;
         drain(30);
         advance = 1'b0;
      end
      check("t2_halted", 32'(halted), 32'd1);
      check("t2_pc", 32'(pc), 32'd3);

      // Jump without advance is ignored; jump with advance wins.
      for (int i = 0; i < 5; i++) load_word(i, rand_word(1'b0));
      load_word(17, rand_word(1'b0));
      do_start();
      drain(20);
      for (int i = 0; i < 4; i++) begin
         do_advance(1'b0, 0);
         drain(20);
      end
      jump_en   = 1'b1;
      jump_addr = AB'(17);
      repeat (3) tick();
      jump_en = 1'b0;
      check("t3_pc_no_advance", 32'(pc), 32'd4);
      check("t3_valid_no_advance", 32'(instr_valid), 32'd1);
      do_advance(1'b1, 17);
      drain(20);
      check("t3_pc_jump", 32'(pc), 32'd17);

      // Full memory of non-halt words: 31 wraps to 0.
      do_reset();
      for (int i = 0; i < DEPTH; i++) load_word(i, rand_word(1'b0));
      do_start();
      drain(20);
      for (int i = 0; i < DEPTH; i++) begin
         do_advance(1'b0, 0);
         drain(20);
      end
      check("t4_wrap_pc", 32'(pc), 32'd0);
      check("t4_no_halt", 32'(halted), 32'd0);

      // Load and start while running are ignored.
      old_word = model_mem[2];
      load_word(2, ~old_word);
      do_start();
      repeat (3) tick();
      do_advance(1'b0, 0);
      drain(20);
      do_advance(1'b0, 0);
      drain(20);
      check("t5_mem2_kept", 32'(instr), 32'(old_word));

      // Reset while holding pc 9, then restart from the preserved program.
      for (int i = 0; i < 7; i++) begin
         do_advance(1'b0, 0);
         drain(20);
      end
      check("t6_pc_before_rst", 32'(pc), 32'd9);
      do_reset();
      do_start();
      drain(20);
      check("t6_restart_word", 32'(instr), 32'(model_mem[0]));

      // Randomized operation with halts, jumps and ignored noise.
      do_reset();
      for (int i = 0; i < DEPTH; i++) load_word(i, rand_word(1'b1));
      for (int it = 0; it < 300; it++) begin
         if (m_mode == M_RUN) begin
            repeat ($urandom_range(2)) begin
               case ($urandom_range(2))
                  0: begin
                     jump_en   = 1'b1;
                     jump_addr = AB'($urandom_range(DEPTH - 1));
                     tick();
                     jump_en = 1'b0;
                  end
                  1: load_word($urandom_range(DEPTH - 1), rand_word(1'b1));
                  default: do_start();
               endcase
            end
            do_advance($urandom_range(3) == 0, $urandom_range(DEPTH - 1));
         end else begin
            repeat ($urandom_range(2)) load_word($urandom_range(DEPTH - 1), rand_word(1'b1));
            do_start();
         end
         drain(20);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter INSTR_WIDTH, default 20, instruction word width.
REQ-002 SHALL have parameter ADDR_BITS, default 5, program address width (32 words).
REQ-003 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, begin execution at address 0.
REQ-006 SHALL have ports ld_en, input, 1; ld_addr, input, ADDR_BITS; ld_data, input, INSTR_WIDTH; program load write port.
REQ-007 SHALL have port advance, input, 1, downstream control unit has consumed the current instruction.
REQ-008 SHALL have ports jump_en, input, 1; jump_addr, input, ADDR_BITS; next-PC override.
REQ-009 SHALL have port instr, output, INSTR_WIDTH, registered instruction to the control unit.
REQ-010 SHALL have port instr_valid, output, 1, instr holds a freshly fetched non-halt word.
REQ-011 SHALL have port pc, output, ADDR_BITS, address of the word in instr.
REQ-012 SHALL have port halted, output, 1, halt word reached.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, HOLD, HALT.
REQ-014 IDLE: start=1 -> FETCH with pc<=0; otherwise remain.
REQ-015 FETCH: one synchronous memory read of mem[pc]; on the next edge instr<=mem[pc].
REQ-016 FETCH: if the fetched word has bits [19:18]==00, go to HALT with instr_valid=0 and halted=1; otherwise go to HOLD with instr_valid=1.
REQ-017 Latency: start sampled at edge N -> instr/instr_valid valid after edge N+2.
REQ-018 HOLD: instr, pc and instr_valid hold stable until advance=1.
REQ-019 HOLD with advance=1: pc<=jump_addr if jump_en=1, else pc<=pc+1; instr_valid<=0; go to FETCH.
REQ-020 pc+1 SHALL wrap modulo 2^ADDR_BITS (31 -> 0).
REQ-021 jump_en without advance SHALL be ignored; jump_en with advance SHALL take priority over increment.
REQ-022 advance outside HOLD SHALL be ignored.
REQ-023 During FETCH, instr SHALL retain its previous value while instr_valid=0.
REQ-024 HALT: instr_valid=0 and halted=1; start=1 -> FETCH with pc<=0 and halted<=0.
REQ-025 ld_en SHALL write ld_data to mem[ld_addr] only in IDLE or HALT and SHALL be ignored in FETCH and HOLD.
REQ-026 start in FETCH or HOLD SHALL be ignored.
REQ-027 A load and a fetch of the same address in the same cycle cannot occur (REQ-025 guarantees this).

Reset
REQ-028 rst=1 SHALL force state=IDLE, pc=0, instr=0, instr_valid=0 and halted=0 at the next edge, from any state, including mid-fetch.
REQ-029 Reset SHALL NOT clear program memory contents.
REQ-030 While in IDLE, instr SHALL read as all-zero (type 00), which keeps the control unit in its reset state.

Structure
REQ-031 A shared package SHALL hold INSTR_WIDTH, ADDR_BITS, the instruction type codes (00 halt/nop, 01 std_op, 10 loadR, 11 storeR) and the FSM state encodings.
REQ-032 Program storage SHALL be a sub-module instr_mem: 2^ADDR_BITS x INSTR_WIDTH, one synchronous read port and one write port, no reset.

Verification
REQ-033 Load mem[0]=20'h4_1235 and mem[1]=0; pulse start -> instr=20'h4_1235, instr_valid=1, pc=0 after edge N+2; on advance -> halted=1, instr_valid=0, pc=1.
REQ-034 Load 3 std_op words at addresses 0-2 and a halt word at 3; hold advance=1 continuously -> instr_valid pulses on alternate cycles at pc=0,1,2, then halted=1.
REQ-035 In HOLD at pc=4: assert advance=1, jump_en=1, jump_addr=17 -> next fetch at pc=17; jump_en=1 without advance -> pc stays 4.
REQ-036 Fill all 32 words with non-halt values and start -> pc 31 advances to pc 0 with no halt.
REQ-037 Assert rst in HOLD at pc=9 -> after one edge state IDLE, instr=0, pc=0, instr_valid=0; restart -> mem[0] returns its preloaded value.
REQ-038 Pulse ld_en to mem[2] during HOLD -> mem[2] unchanged when later fetched; start during HOLD -> no effect.
